fetch_btb: RTL and testbench

FETCH_BTB -- requirements
Module: fetch_btb

---
 rtl/fetch_btb.sv | 113 +++++++++++
 tb/tb_fetch_btb.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_btb.sv
`default_nettype none
// ============================================================================
// Module      : fetch_btb
// Description : Fetch-stage PC register with a direct-mapped branch target
//               buffer.  Each entry holds valid, tag, target and a 2-bit
//               saturating counter.  Lookup is combinational on pc_o and
//               updates from resolved branches become visible next cycle.
//               Optional macro BTB_PERF_CNT_EN adds hit_cnt / redirect_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_btb #(
  parameter int ENTRIES = 32,
  parameter int IDX_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_write,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  output logic [31:0] pc_o,
  output logic        pred_taken_o,
`ifdef BTB_PERF_CNT_EN
  output logic [31:0] pred_target_o,
  output logic [31:0] hit_cnt,
  output logic [31:0] redirect_cnt
`else
  output logic [31:0] pred_target_o
`endif
);

  localparam int TAG_W = 32 - IDX_W;

  logic             valid  [ENTRIES];
  logic [TAG_W-1:0] tag    [ENTRIES];
  logic [31:0]      target [ENTRIES];
  logic [1:0]       ctr    [ENTRIES];

  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] upd_idx;
  logic             fetch_hit;
  logic             upd_hit;
  logic [31:0]      pc_plus1;

  // Combinational lookup at the current fetch PC and at the update PC
  always_comb begin
    fetch_idx     = pc_o[IDX_W-1:0];
    upd_idx       = upd_pc[IDX_W-1:0];
    fetch_hit     = valid[fetch_idx] && (tag[fetch_idx] == pc_o[31:IDX_W]);
    upd_hit       = valid[upd_idx] && (tag[upd_idx] == upd_pc[31:IDX_W]);
    pc_plus1      = pc_o + 32'd1;
    pred_taken_o  = fetch_hit && ctr[fetch_idx][1];
    pred_target_o = pred_taken_o ? target[fetch_idx] : pc_plus1;
  end

  // Fetch PC: reset, then redirect, then stall, then predicted next PC
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_o <= 32'h0000_0000;
    end else if (redirect_valid) begin
      pc_o <= redirect_pc;
    end else if (pc_write) begin
      pc_o <= pred_target_o;
    end
  end

  // Valid bits and counters: cleared by reset, trained by resolved branches
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid[i] <= 1'b0;
        ctr[i]   <= 2'b00;
      end
    end else if (upd_valid) begin
      if (upd_hit) begin
        if (upd_taken) begin
          if (ctr[upd_idx] != 2'b11) ctr[upd_idx] <= ctr[upd_idx] + 2'b01;
        end else begin
          if (ctr[upd_idx] != 2'b00) ctr[upd_idx] <= ctr[upd_idx] - 2'b01;
        end
      end else if (upd_taken) begin
        valid[upd_idx] <= 1'b1;
        ctr[upd_idx]   <= 2'b10;
      end
    end
  end

  // Tag and target storage; no reset needed since valid qualifies them
  always_ff @(posedge clk) begin
    if (!rst && upd_valid && upd_taken) begin
      target[upd_idx] <= upd_target;
      if (!upd_hit) tag[upd_idx] <= upd_pc[31:IDX_W];
    end
  end

`ifdef BTB_PERF_CNT_EN
  // Performance counters: hits on advancing fetches and redirect cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt      <= 32'd0;
      redirect_cnt <= 32'd0;
    end else begin
      if (fetch_hit && pc_write) hit_cnt <= hit_cnt + 32'd1;
      if (redirect_valid) redirect_cnt <= redirect_cnt + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_btb.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_btb
// Description : Directed self-checking bench for fetch_btb.  Build with
//               BTB_PERF_CNT_EN defined to also check the perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_btb;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_write;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [31:0] pc_o;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
`ifdef BTB_PERF_CNT_EN
  logic [31:0] hit_cnt;
  logic [31:0] redirect_cnt;
`endif

  int vectors = 0;
  int errors  = 0;

  fetch_btb #(.ENTRIES(32), .IDX_W(5)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_write       (pc_write),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .pc_o           (pc_o),
    .pred_taken_o   (pred_taken_o),
`ifdef BTB_PERF_CNT_EN
    .pred_target_o  (pred_target_o),
    .hit_cnt        (hit_cnt),
    .redirect_cnt   (redirect_cnt)
`else
    .pred_target_o  (pred_target_o)
`endif
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Check fetch PC and full prediction in one go
  task automatic chk_pred(input string name, input logic [31:0] pc,
                          input logic pt, input logic [31:0] tgt);
    chk({name, ".pc"}, pc_o, pc);
    chk({name, ".taken"}, {31'd0, pred_taken_o}, {31'd0, pt});
    chk({name, ".target"}, pred_target_o, tgt);
  endtask

  task automatic perf(input string name, input logic [31:0] hits, input logic [31:0] redirs);
`ifdef BTB_PERF_CNT_EN
    chk({name, ".hit_cnt"}, hit_cnt, hits);
    chk({name, ".redirect_cnt"}, redirect_cnt, redirs);
`else
    if (hits === redirs) begin end
`endif
  endtask

  task automatic upd(input logic v, input logic [31:0] p, input logic t, input logic [31:0] tg);
    upd_valid  = v;
    upd_pc     = p;
    upd_taken  = t;
    upd_target = tg;
  endtask

  task automatic redir(input logic v, input logic [31:0] p);
    redirect_valid = v;
    redirect_pc    = p;
  endtask

  initial begin
    rst = 1'b1;
    pc_write = 1'b1;
    redir(1'b0, 32'h0);
    upd(1'b0, 32'h0, 1'b0, 32'h0);

    // Reset state
    tick();
    chk_pred("reset", 32'h0, 1'b0, 32'h1);
    perf("reset", 32'd0, 32'd0);
    rst = 1'b0;

    // Sequential fetch from 0
    tick(); chk_pred("seq1", 32'h1, 1'b0, 32'h2);
    tick(); chk_pred("seq2", 32'h2, 1'b0, 32'h3);
    tick(); chk_pred("seq3", 32'h3, 1'b0, 32'h4);

    // Allocate taken branch 0x8 -> 0x2
    upd(1'b1, 32'h8, 1'b1, 32'h2);
    tick(); upd(1'b0, 32'h0, 1'b0, 32'h0);
    chk_pred("seq4", 32'h4, 1'b0, 32'h5);
    tick(); tick(); tick();
    chk_pred("seq7", 32'h7, 1'b0, 32'h8);
    tick(); chk_pred("hit8", 32'h8, 1'b1, 32'h2);
    tick(); chk_pred("loop2", 32'h2, 1'b0, 32'h3);
    tick(); tick(); tick();
    chk_pred("loop5", 32'h5, 1'b0, 32'h6);

    // Stall at 5, then redirect overrides the stall
    pc_write = 1'b0;
    tick(); chk("stall5", pc_o, 32'h5);
    redir(1'b1, 32'h40);
    tick(); chk("redir40", pc_o, 32'h40);
    redir(1'b0, 32'h0);
    pc_write = 1'b1;
    perf("after_stall", 32'd1, 32'd1);

    // Counter 2 -> 1: entry still hits but predicts fall-through
    upd(1'b1, 32'h8, 1'b0, 32'h77);
    redir(1'b1, 32'h8);
    tick(); redir(1'b0, 32'h0);
    chk_pred("ctr1", 32'h8, 1'b0, 32'h9);
    // 1 -> 0, then saturate at 0
    tick(); tick();
    chk("seq10", pc_o, 32'ha);
    // 0 -> 1 with new target; still not taken
    upd(1'b1, 32'h8, 1'b1, 32'h30);
    tick(); upd(1'b0, 32'h0, 1'b0, 32'h0);
    redir(1'b1, 32'h8);
    tick(); redir(1'b0, 32'h0);
    chk_pred("ctr1b", 32'h8, 1'b0, 32'h9);
    // 1 -> 2: taken to the rewritten target
    upd(1'b1, 32'h8, 1'b1, 32'h30);
    tick(); upd(1'b0, 32'h0, 1'b0, 32'h0);
    redir(1'b1, 32'h8);
    tick(); redir(1'b0, 32'h0);
    chk_pred("ctr2", 32'h8, 1'b1, 32'h30);
    // Three taken (2 -> 3, saturate), two not-taken -> 1
    upd(1'b1, 32'h8, 1'b1, 32'h30);
    tick();
    chk("follow30", pc_o, 32'h30);
    tick(); tick();
    upd(1'b1, 32'h8, 1'b0, 32'h30);
    tick(); tick();
    upd(1'b0, 32'h0, 1'b0, 32'h0);
    redir(1'b1, 32'h8);
    tick(); redir(1'b0, 32'h0);
    chk_pred("ctr_sat", 32'h8, 1'b0, 32'h9);
    perf("after_train", 32'd4, 32'd5);

    // Alias: 0x28 shares the index with 0x8 and evicts it
    upd(1'b1, 32'h28, 1'b1, 32'h50);
    redir(1'b1, 32'h8);
    tick(); upd(1'b0, 32'h0, 1'b0, 32'h0);
    chk_pred("evicted8", 32'h8, 1'b0, 32'h9);
    redir(1'b1, 32'h28);
    tick(); redir(1'b0, 32'h0);
    chk_pred("alias28", 32'h28, 1'b1, 32'h50);

    // Not-taken update on a miss leaves the table alone
    upd(1'b1, 32'h48, 1'b0, 32'h99);
    tick(); upd(1'b0, 32'h0, 1'b0, 32'h0);
    chk("follow50", pc_o, 32'h50);
    redir(1'b1, 32'h28);
    tick(); redir(1'b0, 32'h0);
    chk_pred("still28", 32'h28, 1'b1, 32'h50);
    perf("before_rst", 32'd6, 32'd8);

    // Reset wins over redirect and a pending taken update
    rst = 1'b1;
    upd(1'b1, 32'h10, 1'b1, 32'h99);
    redir(1'b1, 32'h40);
    tick();
    rst = 1'b0;
    upd(1'b0, 32'h0, 1'b0, 32'h0);
    redir(1'b0, 32'h0);
    chk_pred("rst2", 32'h0, 1'b0, 32'h1);
    perf("rst2", 32'd0, 32'd0);
    redir(1'b1, 32'h28);
    tick();
    chk_pred("cleared28", 32'h28, 1'b0, 32'h29);
    redir(1'b1, 32'h10);
    tick();
    chk_pred("dropped10", 32'h10, 1'b0, 32'h11);

    // Sequential wrap at the top of the address space
    redir(1'b1, 32'hFFFF_FFFF);
    tick(); redir(1'b0, 32'h0);
    chk_pred("top", 32'hFFFF_FFFF, 1'b0, 32'h0);
    tick();
    chk("wrap", pc_o, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
